mips_multicycle_ctrl: RTL and testbench

- Multi-cycle control FSM for the MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives the 5-bit ALU operation select, datapath mux selects and register/PC/IR write enables.
- Waits on a memory ready handshake; sits between the instruction register decode fields and the ALU/register-file/memory datapath.

---
 rtl/mips_ctrl_pkg.sv | 75 +++++++
 rtl/mips_alu_decode.sv | 54 +++++
 rtl/mips_multicycle_ctrl.sv | 156 +++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: ALU ops, opcodes,
// function codes, FSM states and datapath mux selects.
package mips_ctrl_pkg;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_ADDU = 5'd1;
  localparam logic [4:0] ALU_SUB  = 5'd2;
  localparam logic [4:0] ALU_SUBU = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_OR   = 5'd5;
  localparam logic [4:0] ALU_NOR  = 5'd6;
  localparam logic [4:0] ALU_SLT  = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_JR   = 5'd11;
  localparam logic [4:0] ALU_NOP  = 5'd12;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_R_EXEC    = 4'd2,
    S_R_WB      = 4'd3,
    S_JR        = 4'd4,
    S_MEM_ADDR  = 4'd5,
    S_MEM_READ  = 4'd6,
    S_MEM_WB    = 4'd7,
    S_MEM_WRITE = 4'd8,
    S_BRANCH    = 4'd9,
    S_JUMP      = 4'd10,
    S_I_EXEC    = 4'd11,
    S_I_WB      = 4'd12
  } state_e;

  localparam logic [1:0] ALUB_RT      = 2'd0;
  localparam logic [1:0] ALUB_FOUR    = 2'd1;
  localparam logic [1:0] ALUB_IMM     = 2'd2;
  localparam logic [1:0] ALUB_IMM_SL2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_RS     = 2'd3;

  function automatic logic is_imm_alu(input logic [5:0] op);
    return (op == OP_ADDI) || (op == OP_ADDIU) || (op == OP_SLTI) ||
           (op == OP_ANDI) || (op == OP_ORI);
  endfunction

endpackage

// File: rtl/mips_alu_decode.sv
// ALU operation select for the current controller state; flags R-type
// function codes the datapath does not implement.
module mips_alu_decode
  import mips_ctrl_pkg::*;
(
  input  state_e     state_i,
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output logic [4:0] alu_op_o,
  output logic       funct_illegal_o
);

  always_comb begin
    alu_op_o        = ALU_ADD;
    funct_illegal_o = 1'b0;
    case (state_i)
      S_FETCH, S_DECODE: alu_op_o = ALU_ADDU;
      S_R_EXEC: begin
        case (funct_i)
          F_ADD:  alu_op_o = ALU_ADD;
          F_ADDU: alu_op_o = ALU_ADDU;
          F_SUB:  alu_op_o = ALU_SUB;
          F_SUBU: alu_op_o = ALU_SUBU;
          F_AND:  alu_op_o = ALU_AND;
          F_OR:   alu_op_o = ALU_OR;
          F_NOR:  alu_op_o = ALU_NOR;
          F_SLT:  alu_op_o = ALU_SLT;
          F_SLL:  alu_op_o = ALU_SLL;
          F_SRL:  alu_op_o = ALU_SRL;
          F_SRA:  alu_op_o = ALU_SRA;
          F_JR:   alu_op_o = ALU_JR;
          default: begin
            alu_op_o        = ALU_NOP;
            funct_illegal_o = 1'b1;
          end
        endcase
      end
      S_JR:       alu_op_o = ALU_JR;
      S_MEM_ADDR: alu_op_o = ALU_ADD;
      S_BRANCH:   alu_op_o = ALU_SUB;
      S_I_EXEC: begin
        case (opcode_i)
          OP_ADDIU: alu_op_o = ALU_ADDU;
          OP_SLTI:  alu_op_o = ALU_SLT;
          OP_ANDI:  alu_op_o = ALU_AND;
          OP_ORI:   alu_op_o = ALU_OR;
          default:  alu_op_o = ALU_ADD;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/
// writeback and decodes datapath controls from the current state.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4,
  parameter int ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode_i,
  input  logic [5:0]         funct_i,
  input  logic               alu_zero_i,
  input  logic               mem_ready_i,
  output logic               pc_write_o,
  output logic               pc_write_cond_o,
  output logic               iord_o,
  output logic               mem_read_o,
  output logic               mem_write_o,
  output logic               ir_write_o,
  output logic               reg_dst_o,
  output logic               mem_to_reg_o,
  output logic               reg_write_o,
  output logic               alu_src_a_o,
  output logic [1:0]         alu_src_b_o,
  output logic [1:0]         pc_source_o,
  output logic [ALUOP_W-1:0] alu_op_o,
  output logic [STATE_W-1:0] state_o,
  output logic               illegal_o
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic [4:0] alu_op_dec;
  logic       funct_illegal;

  mips_alu_decode u_alu_decode (
    .state_i         (state_q),
    .opcode_i        (opcode_i),
    .funct_i         (funct_i),
    .alu_op_o        (alu_op_dec),
    .funct_illegal_o (funct_illegal)
  );

  always_comb begin
    state_d   = S_FETCH;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH: state_d = mem_ready_i ? S_DECODE : S_FETCH;
      S_DECODE: begin
        if (opcode_i == OP_RTYPE)                         state_d = S_R_EXEC;
        else if (opcode_i == OP_LW || opcode_i == OP_SW)  state_d = S_MEM_ADDR;
        else if (opcode_i == OP_BEQ || opcode_i == OP_BNE) state_d = S_BRANCH;
        else if (opcode_i == OP_J)                        state_d = S_JUMP;
        else if (is_imm_alu(opcode_i))                    state_d = S_I_EXEC;
        else                                              illegal_d = 1'b1;
      end
      S_R_EXEC: begin
        if (funct_illegal)        illegal_d = 1'b1;
        else if (funct_i == F_JR) state_d = S_JR;
        else                      state_d = S_R_WB;
      end
      S_MEM_ADDR: begin
        if (opcode_i == OP_LW)      state_d = S_MEM_READ;
        else if (opcode_i == OP_SW) state_d = S_MEM_WRITE;
      end
      S_MEM_READ:  state_d = mem_ready_i ? S_MEM_WB : S_MEM_READ;
      S_MEM_WRITE: state_d = mem_ready_i ? S_FETCH : S_MEM_WRITE;
      S_I_EXEC:    state_d = S_I_WB;
      default:     state_d = S_FETCH;
    endcase
  end

  // The illegal flag is registered so it shows as a clean one-cycle pulse
  // in the FETCH that follows the rejected instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Outputs are held quiet while reset is asserted so a write in flight is
  // dropped immediately rather than at the next clock.
  always_comb begin
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    iord_o          = 1'b0;
    mem_read_o      = 1'b0;
    mem_write_o     = 1'b0;
    ir_write_o      = 1'b0;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write_o     = 1'b0;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = ALUB_RT;
    pc_source_o     = PCSRC_ALU;
    alu_op_o        = '0;
    if (rst_n) begin
      alu_op_o = ALUOP_W'(alu_op_dec);
      case (state_q)
        S_FETCH: begin
          mem_read_o  = 1'b1;
          alu_src_b_o = ALUB_FOUR;
          ir_write_o  = mem_ready_i;
          pc_write_o  = mem_ready_i;
        end
        S_DECODE: alu_src_b_o = ALUB_IMM_SL2;
        S_R_EXEC: alu_src_a_o = 1'b1;
        S_R_WB: begin
          reg_write_o = 1'b1;
          reg_dst_o   = 1'b1;
        end
        S_JR: begin
          pc_write_o  = 1'b1;
          pc_source_o = PCSRC_RS;
        end
        S_MEM_ADDR, S_I_EXEC: begin
          alu_src_a_o = 1'b1;
          alu_src_b_o = ALUB_IMM;
        end
        S_MEM_READ: begin
          mem_read_o = 1'b1;
          iord_o     = 1'b1;
        end
        S_MEM_WB: begin
          reg_write_o  = 1'b1;
          mem_to_reg_o = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_write_o = 1'b1;
          iord_o      = 1'b1;
        end
        S_BRANCH: begin
          alu_src_a_o     = 1'b1;
          pc_source_o     = PCSRC_ALUOUT;
          pc_write_cond_o = 1'b1;
          pc_write_o      = (opcode_i == OP_BNE) ? !alu_zero_i : alu_zero_i;
        end
        S_JUMP: begin
          pc_write_o  = 1'b1;
          pc_source_o = PCSRC_JUMP;
        end
        S_I_WB: reg_write_o = 1'b1;
        default: ;
      endcase
    end
  end

  assign state_o   = STATE_W'(state_q);
  assign illegal_o = illegal_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed and randomized instruction streams checked cycle by cycle
// against an instruction-level model of the controller.
module tb_mips_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode_i, funct_i;
  logic       alu_zero_i, mem_ready_i;
  logic       pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o;
  logic       ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o;
  logic [1:0] alu_src_b_o, pc_source_o;
  logic [4:0] alu_op_o;
  logic [3:0] state_o;
  logic       illegal_o;

  int errors = 0;
  int checks = 0;
  bit pend_illegal = 1'b0;

  typedef struct packed {
    logic       pc_write, pc_write_cond, iord, mem_read, mem_write;
    logic       ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b, pc_source;
    logic [4:0] alu_op;
  } out_t;

  typedef struct {
    state_e s;
    logic   rdy;
  } step_t;

  out_t obs;
  assign obs = {pc_write_o, pc_write_cond_o, iord_o, mem_read_o, mem_write_o,
                ir_write_o, reg_dst_o, mem_to_reg_o, reg_write_o, alu_src_a_o,
                alu_src_b_o, pc_source_o, alu_op_o};

  always #5 clk = ~clk;

  mips_multicycle_ctrl #(.STATE_W(4), .ALUOP_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .opcode_i(opcode_i), .funct_i(funct_i),
    .alu_zero_i(alu_zero_i), .mem_ready_i(mem_ready_i),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .iord_o(iord_o),
    .mem_read_o(mem_read_o), .mem_write_o(mem_write_o), .ir_write_o(ir_write_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .pc_source_o(pc_source_o),
    .alu_op_o(alu_op_o), .state_o(state_o), .illegal_o(illegal_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ALU code an R-type function maps to; 12 (NOP) when unsupported.
  function automatic logic [4:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20: return 5'd0;
      6'h21: return 5'd1;
      6'h22: return 5'd2;
      6'h23: return 5'd3;
      6'h24: return 5'd4;
      6'h25: return 5'd5;
      6'h27: return 5'd6;
      6'h2A: return 5'd7;
      6'h00: return 5'd8;
      6'h02: return 5'd9;
      6'h03: return 5'd10;
      6'h08: return 5'd11;
      default: return 5'd12;
    endcase
  endfunction

  function automatic logic [4:0] i_alu(input logic [5:0] op);
    case (op)
      6'h09: return 5'd1;
      6'h0A: return 5'd7;
      6'h0C: return 5'd4;
      6'h0D: return 5'd5;
      default: return 5'd0;
    endcase
  endfunction

  function automatic out_t exp_out(input state_e s, input logic [5:0] op,
                                   input logic [5:0] fn, input logic zero, input logic rdy);
    out_t o = '0;
    case (s)
      S_FETCH: begin
        o.mem_read = 1; o.alu_src_b = 2'd1; o.alu_op = 5'd1;
        o.ir_write = rdy; o.pc_write = rdy;
      end
      S_DECODE:    begin o.alu_src_b = 2'd3; o.alu_op = 5'd1; end
      S_R_EXEC:    begin o.alu_src_a = 1; o.alu_op = r_alu(fn); end
      S_R_WB:      begin o.reg_write = 1; o.reg_dst = 1; end
      S_JR:        begin o.pc_write = 1; o.pc_source = 2'd3; o.alu_op = 5'd11; end
      S_MEM_ADDR:  begin o.alu_src_a = 1; o.alu_src_b = 2'd2; end
      S_MEM_READ:  begin o.mem_read = 1; o.iord = 1; end
      S_MEM_WB:    begin o.reg_write = 1; o.mem_to_reg = 1; end
      S_MEM_WRITE: begin o.mem_write = 1; o.iord = 1; end
      S_BRANCH: begin
        o.alu_src_a = 1; o.alu_op = 5'd2; o.pc_source = 2'd1; o.pc_write_cond = 1;
        o.pc_write = (op == 6'h04) ? zero : !zero;
      end
      S_JUMP:   begin o.pc_write = 1; o.pc_source = 2'd2; end
      S_I_EXEC: begin o.alu_src_a = 1; o.alu_src_b = 2'd2; o.alu_op = i_alu(op); end
      S_I_WB:   o.reg_write = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic one_step(input state_e s, input logic rdy, input logic exp_ill);
    mem_ready_i = rdy;
    @(negedge clk);
    check($sformatf("state_%s", s.name()), 32'(state_o), 32'(s));
    check($sformatf("outs_%s", s.name()), 32'(obs),
          32'(exp_out(s, opcode_i, funct_i, alu_zero_i, rdy)));
    check($sformatf("illegal_%s", s.name()), 32'(illegal_o), 32'(exp_ill));
    @(posedge clk);
    #1;
  endtask

  // Builds the expected state walk for one instruction and checks each cycle.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input logic zero, input int fw, input int mw);
    step_t q[$];
    bit    ill = 1'b0;
    for (int i = 0; i < fw; i++) q.push_back('{S_FETCH, 1'b0});
    q.push_back('{S_FETCH, 1'b1});
    q.push_back('{S_DECODE, rnd()});
    case (op)
      6'h00: begin
        q.push_back('{S_R_EXEC, rnd()});
        if (fn == 6'h08)               q.push_back('{S_JR, rnd()});
        else if (r_alu(fn) == 5'd12)   ill = 1'b1;
        else                           q.push_back('{S_R_WB, rnd()});
      end
      6'h23: begin
        q.push_back('{S_MEM_ADDR, rnd()});
        for (int i = 0; i < mw; i++) q.push_back('{S_MEM_READ, 1'b0});
        q.push_back('{S_MEM_READ, 1'b1});
        q.push_back('{S_MEM_WB, rnd()});
      end
      6'h2B: begin
        q.push_back('{S_MEM_ADDR, rnd()});
        for (int i = 0; i < mw; i++) q.push_back('{S_MEM_WRITE, 1'b0});
        q.push_back('{S_MEM_WRITE, 1'b1});
      end
      6'h04, 6'h05: q.push_back('{S_BRANCH, rnd()});
      6'h02:        q.push_back('{S_JUMP, rnd()});
      6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D: begin
        q.push_back('{S_I_EXEC, rnd()});
        q.push_back('{S_I_WB, rnd()});
      end
      default: ill = 1'b1;
    endcase
    opcode_i   = op;
    funct_i    = fn;
    alu_zero_i = zero;
    foreach (q[k]) one_step(q[k].s, q[k].rdy, (k == 0) ? pend_illegal : 1'b0);
    pend_illegal = ill;
  endtask

  logic [5:0] op_pool [14] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h08,
                               6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h3F, 6'h01, 6'h10};
  logic [5:0] fn_pool [14] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h27,
                               6'h2A, 6'h00, 6'h02, 6'h03, 6'h08, 6'h26, 6'h01};

  initial begin
    rst_n = 1'b0; opcode_i = '0; funct_i = '0; alu_zero_i = 1'b0; mem_ready_i = 1'b1;
    #3;
    check("reset_state", 32'(state_o), 32'(S_FETCH));
    check("reset_outs", 32'(obs), 32'd0);
    check("reset_illegal", 32'(illegal_o), 32'd0);
    @(posedge clk); @(posedge clk); #2;
    mem_ready_i = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_instr(6'h00, 6'h22, 1'b0, 0, 0);  // sub
    run_instr(6'h23, 6'h00, 1'b0, 0, 3);  // lw with three wait cycles
    run_instr(6'h04, 6'h00, 1'b1, 0, 0);  // beq taken
    run_instr(6'h05, 6'h00, 1'b1, 0, 0);  // bne not taken
    run_instr(6'h3F, 6'h00, 1'b0, 0, 0);  // illegal opcode
    run_instr(6'h02, 6'h00, 1'b0, 1, 0);  // jump, first cycle shows illegal pulse
    run_instr(6'h00, 6'h08, 1'b0, 0, 0);  // jr
    run_instr(6'h2B, 6'h00, 1'b0, 2, 1);  // sw with waits

    for (int n = 0; n < 80; n++)
      run_instr(op_pool[$urandom_range(0, 13)], fn_pool[$urandom_range(0, 13)],
                rnd(), $urandom_range(0, 2), $urandom_range(0, 3));

    run_instr(6'h09, 6'h00, 1'b0, 0, 0);
    opcode_i = 6'h2B;
    one_step(S_FETCH, 1'b1, pend_illegal);
    one_step(S_DECODE, 1'b0, 1'b0);
    one_step(S_MEM_ADDR, 1'b1, 1'b0);
    mem_ready_i = 1'b0;
    #2;
    check("sw_write_pending", 32'(mem_write_o), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_mem_write", 32'(mem_write_o), 32'd0);
    check("async_rst_state", 32'(state_o), 32'(S_FETCH));
    check("async_rst_outs", 32'(obs), 32'd0);
    check("async_rst_illegal", 32'(illegal_o), 32'd0);
    @(posedge clk); #1;
    check("held_rst_outs", 32'(obs), 32'd0);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    pend_illegal = 1'b0;
    run_instr(6'h00, 6'h2A, 1'b0, 0, 0);  // slt after recovery
    run_instr(6'h0D, 6'h00, 1'b0, 1, 0);  // ori

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
